// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// and delivers {pc, instr} to IF/ID. Optional MIPS delay slot via DELAY_SLOT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          WAIT_LIMIT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] pc_cur_o,
    output logic        fetch_err_o
);

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tgt_q, tgt_d;
    logic          drop_q, drop_d;
    logic          tgt_pend_q, tgt_pend_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          if_valid_q, if_valid_d;
    logic [31:0]   if_pc_q, if_pc_d;
    logic [31:0]   if_instr_q, if_instr_d;
    logic          fetch_err_q, fetch_err_d;

    logic [31:0]   redir_tgt;
    logic          squash;
    logic          redir_lsb_unused;

    assign redir_tgt        = {redir_pc_i[31:2], 2'b00};
    assign redir_lsb_unused = ^redir_pc_i[1:0];
    // Without a delay slot a redirect kills whatever is in flight.
    assign squash           = redir_valid_i & ~DS;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            drop_q      <= 1'b0;
            tgt_pend_q  <= 1'b0;
            wait_cnt_q  <= '0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            drop_q      <= drop_d;
            tgt_pend_q  <= tgt_pend_d;
            wait_cnt_q  <= wait_cnt_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        drop_d      = drop_q;
        tgt_pend_d  = tgt_pend_q;
        wait_cnt_d  = wait_cnt_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        fetch_err_d = fetch_err_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redir_valid_i) pc_d = redir_tgt;
            end

            S_REQ: begin
                if (imem_gnt_i) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
                if (redir_valid_i) begin
                    if (DS) begin
                        tgt_d      = redir_tgt;
                        tgt_pend_d = 1'b1;
                    end else if (imem_gnt_i) begin
                        // Granted this cycle: the old address is in flight, discard it.
                        drop_d = 1'b1;
                        tgt_d  = redir_tgt;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end
            end

            S_WAIT: begin
                if (redir_valid_i && DS) begin
                    tgt_d      = redir_tgt;
                    tgt_pend_d = 1'b1;
                end
                if (imem_rvalid_i) begin
                    if (squash) begin
                        pc_d    = redir_tgt;
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (drop_q) begin
                        pc_d    = tgt_q;
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        if_instr_d = imem_rdata_i;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else begin
                    if (squash) begin
                        drop_d = 1'b1;
                        tgt_d  = redir_tgt;
                    end
                    if (wait_cnt_q == CNT_LAST) begin
                        fetch_err_d = 1'b1;
                        wait_cnt_d  = '0;
                        state_d     = S_REQ;
                        // A pending squash retargets the re-issue instead of the dead address.
                        if (drop_d) begin
                            pc_d   = tgt_d;
                            drop_d = 1'b0;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (squash) begin
                    if_valid_d = 1'b0;
                    pc_d       = redir_tgt;
                    state_d    = S_REQ;
                end else begin
                    if (redir_valid_i) begin
                        tgt_d      = redir_tgt;
                        tgt_pend_d = 1'b1;
                    end
                    if (!stall_i) begin
                        if_valid_d = 1'b0;
                        tgt_pend_d = 1'b0;
                        state_d    = S_REQ;
                        if (redir_valid_i)   pc_d = redir_tgt;
                        else if (tgt_pend_q) pc_d = tgt_q;
                        else                 pc_d = pc_q + 32'd4;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req_o  = (state_q == S_REQ);
    assign imem_addr_o = pc_q;
    assign pc_cur_o    = pc_q;
    assign if_valid_o  = if_valid_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;
    assign fetch_err_o = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: reactive imem model, grant/delivery scoreboards,
// table-driven straight-line fetch plus hand sequences for stall, redirect, timeout, wrap, reset.
module tb_fetch_ctrl;
    localparam int WL = 6;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        redir = 1'b0, stall = 1'b0, gnt = 1'b1, rvalid = 1'b0;
    logic [31:0] rpc = '0, rdata = '0;
    logic        imem_req, if_valid, fetch_err;
    logic [31:0] addr, if_pc, if_instr, pc_cur;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_3000), .WAIT_LIMIT(WL)) dut (
        .clk_i(clk), .rst_i(rst), .redir_valid_i(redir), .redir_pc_i(rpc), .stall_i(stall),
        .imem_req_o(imem_req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .if_valid_o(if_valid), .if_pc_o(if_pc), .if_instr_o(if_instr),
        .pc_cur_o(pc_cur), .fetch_err_o(fetch_err)
    );

    typedef struct { int lat; logic [31:0] addr; logic [31:0] instr; } vec_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } del_t;

    logic [31:0] exp_addr_q[$];
    del_t        exp_del_q[$];
    int tests = 0, fails = 0;
    int cyc = 0, gcnt = 0, dcyc = 0, dcyc_prev = 0;
    int rv_lat = 0;
    bit withhold = 1'b0;
    logic [31:0] pc;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_addr_q.push_back(a);
        exp_del_q.push_back('{a, hash(a)});
    endtask

    always @(posedge clk) cyc++;

    // imem model: answers a granted request after rv_lat extra cycles, or never if withheld
    logic [31:0] pa;
    int pcnt;
    bit pend = 1'b0;
    always @(posedge clk) begin : mem
        logic g;
        logic [31:0] a;
        g = imem_req && gnt;
        a = addr;
        #1;
        rvalid = 1'b0;
        if (rst) pend = 1'b0;
        else begin
            if (pend) begin
                if (pcnt == 0) begin rvalid = 1'b1; rdata = hash(pa); pend = 1'b0; end
                else pcnt--;
            end
            if (g && !withhold) begin
                pa = a;
                if (rv_lat == 0) begin rvalid = 1'b1; rdata = hash(a); end
                else begin pend = 1'b1; pcnt = rv_lat - 1; end
            end
        end
    end

    // scoreboard monitor: every grant and every new delivery must match the next expectation
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        if (rst) prev_v = 1'b0;
        else begin
            if (imem_req && gnt) begin
                gcnt++;
                if (exp_addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL grant_extra: got request to %h, expected none", addr);
                end else chk("imem_addr", addr, exp_addr_q.pop_front());
            end
            if (if_valid && !prev_v) begin
                dcyc_prev = dcyc;
                dcyc = cyc;
                if (exp_del_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL deliv_extra: got pc %h instr %h, expected none", if_pc, if_instr);
                end else begin
                    del_t d;
                    d = exp_del_q.pop_front();
                    chk("if_pc", if_pc, d.pc);
                    chk("if_instr", if_instr, d.instr);
                end
            end
            prev_v = if_valid;
        end
    end

    task automatic wait_drain(input string nm);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            if (exp_addr_q.size() == 0 && exp_del_q.size() == 0) begin
                #1;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL %s_timeout: got %0d/%0d pending, expected 0/0", nm, exp_addr_q.size(), exp_del_q.size());
        exp_addr_q.delete();
        exp_del_q.delete();
        #1;
    endtask

    task automatic advance();
        @(negedge clk) stall = 1'b0;
        @(negedge clk) stall = 1'b1;
    endtask

    task automatic redir_wait(input int lat, input logic [31:0] t);
        logic [31:0] a;
        a = pc + 32'd4;
        rv_lat = lat;
        exp_addr_q.push_back(a);
        if (DS) exp_del_q.push_back('{a, hash(a)});
        @(negedge clk) stall = 1'b0;
        @(posedge clk); #1 stall = 1'b1;
        @(posedge clk); #1 begin redir = 1'b1; rpc = t; end
        @(posedge clk); #1 redir = 1'b0;
        if (DS) begin
            wait_drain("redir_wait_ds");
            push(t);
            advance();
        end else push(t);
        wait_drain("redir_wait");
        pc = t;
        rv_lat = 0;
    endtask

    task automatic redir_hold(input logic [31:0] raw);
        logic [31:0] t;
        t = {raw[31:2], 2'b00};
        push(t);
        @(negedge clk) begin stall = 1'b0; redir = 1'b1; rpc = raw; end
        @(negedge clk) begin stall = 1'b1; redir = 1'b0; end
        wait_drain("redir_hold");
        pc = t;
    endtask

    initial begin
        vec_t tbl[5];
        tbl[0] = '{0, 32'h0000_3000, hash(32'h0000_3000)};
        tbl[1] = '{0, 32'h0000_3004, hash(32'h0000_3004)};
        tbl[2] = '{0, 32'h0000_3008, hash(32'h0000_3008)};
        tbl[3] = '{2, 32'h0000_300C, hash(32'h0000_300C)};
        tbl[4] = '{0, 32'h0000_3010, hash(32'h0000_3010)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_pc_cur", pc_cur, 32'h0000_3000);

        // sequential fetch, stall low: one delivery every 3 cycles at zero latency
        for (int i = 0; i < 5; i++) begin
            rv_lat = tbl[i].lat;
            exp_addr_q.push_back(tbl[i].addr);
            exp_del_q.push_back('{tbl[i].addr, tbl[i].instr});
            if (i == 4) stall = 1'b1;
            if (i == 0) rst = 1'b0;
            wait_drain("seq");
            if (i > 0 && tbl[i].lat == 0 && tbl[i-1].lat == 0)
                chk("valid_gap", dcyc - dcyc_prev, 3);
        end
        rv_lat = 0;
        pc = 32'h0000_3010;

        // stall in HOLD: outputs frozen, no request
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", if_valid, 1);
            chk("stall_pc", if_pc, pc);
            chk("stall_instr", if_instr, hash(pc));
            chk("stall_req", imem_req, 0);
        end
        pc = pc + 32'd4;
        push(pc);
        advance();
        wait_drain("post_stall");

        // redirect during WAIT: late response, then response in the same cycle
        redir_wait(3, 32'h0000_3100);
        redir_wait(0, 32'h0000_3200);

        // redirect in HOLD with unaligned target, then PC wrap
        redir_hold(32'h0000_3103);
        redir_hold(32'hFFFF_FFFF);
        pc = 32'h0;
        push(pc);
        advance();
        wait_drain("wrap");
        chk("pc_cur_wrap", pc_cur, 32'h0);

        // WAIT timeout: sticky error and the same address re-requested
        withhold = 1'b1;
        pc = pc + 32'd4;
        exp_addr_q.push_back(pc);
        push(pc);
        @(negedge clk) stall = 1'b0;
        @(posedge clk); #1 stall = 1'b1;
        @(posedge clk);
        repeat (WL - 1) @(posedge clk);
        @(negedge clk);
        chk("err_before_limit", fetch_err, 0);
        withhold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("err_at_limit", fetch_err, 1);
        chk("reissue_req", imem_req, 1);
        chk("reissue_addr", addr, pc);
        wait_drain("timeout");
        chk("err_sticky", fetch_err, 1);

        // reset in the middle of a pending fetch
        withhold = 1'b1;
        exp_addr_q.push_back(pc + 32'd4);
        @(negedge clk) stall = 1'b0;
        @(posedge clk); #1 stall = 1'b1;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_valid", if_valid, 0);
        chk("mid_rst_err", fetch_err, 0);
        chk("mid_rst_pc_cur", pc_cur, 32'h0000_3000);
        chk("mid_rst_if_pc", if_pc, 0);
        chk("addr_q_left", exp_addr_q.size(), 0);
        chk("del_q_left", exp_del_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
